fcims_order_ctrl: RTL



---
 rtl/fcims_pkg.sv | 28 ++
 rtl/fcims_seq_mult.sv | 54 +++++
 rtl/fcims_order_ctrl.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/fcims_pkg.sv
// FCIMS order controller shared definitions.
// Holds op codes, error codes, FSM states and default widths.
package fcims_pkg;

    localparam int N_ITEMS_DEF = 4;
    localparam int PRICE_W_DEF = 4;
    localparam int QTY_W_DEF   = 4;
    localparam int TOTAL_W_DEF = 8;

    localparam logic [1:0] OP_SELL       = 2'b00;
    localparam logic [1:0] OP_RESTOCK    = 2'b01;
    localparam logic [1:0] OP_SET_PRICE  = 2'b10;
    localparam logic [1:0] OP_CLOSE_BILL = 2'b11;

    localparam logic [1:0] ERR_NONE  = 2'b00;
    localparam logic [1:0] ERR_STOCK = 2'b01;
    localparam logic [1:0] ERR_OVF   = 2'b10;
    localparam logic [1:0] ERR_BILL  = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_MULT,
        S_COMMIT,
        S_RESP
    } state_e;

endpackage

// File: rtl/fcims_seq_mult.sv
// Sequential shift-add multiplier, one partial product per clock.
// Ports: clk, reset_n, start/a/b in; done/product out (done B_W cycles after start).
module fcims_seq_mult #(
    parameter int A_W = 4,
    parameter int B_W = 4,
    parameter int P_W = 8
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           start,
    input  logic [A_W-1:0] a,
    input  logic [B_W-1:0] b,
    output logic           done,
    output logic [P_W-1:0] product
);

    localparam int CW = $clog2(B_W + 1);

    logic [P_W-1:0] acc_q;
    logic [P_W-1:0] mcand_q;
    logic [B_W-1:0] mplier_q;
    logic [CW-1:0]  cnt_q;
    logic           busy_q;

    // The start edge already folds in bit 0, so B_W edges cover all bits.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
        end else if (start) begin
            acc_q    <= b[0] ? P_W'(a) : '0;
            mcand_q  <= P_W'(a) << 1;
            mplier_q <= b >> 1;
            cnt_q    <= CW'(B_W - 1);
            busy_q   <= 1'b1;
        end else if (busy_q) begin
            if (cnt_q != '0) begin
                acc_q    <= acc_q + (mplier_q[0] ? mcand_q : '0);
                mcand_q  <= mcand_q << 1;
                mplier_q <= mplier_q >> 1;
                cnt_q    <= cnt_q - 1'b1;
            end else begin
                busy_q <= 1'b0;
            end
        end
    end

    assign done    = busy_q && (cnt_q == '0);
    assign product = acc_q;

endmodule

// File: rtl/fcims_order_ctrl.sv
// Order-entry controller: price/stock tables, bill register and order FSM.
// Ports: req_* handshake in, rsp_* strobe/status out, line_price/stock_out/bill_total out.
module fcims_order_ctrl
    import fcims_pkg::*;
#(
    parameter int N_ITEMS = N_ITEMS_DEF,
    parameter int PRICE_W = PRICE_W_DEF,
    parameter int QTY_W   = QTY_W_DEF,
    parameter int TOTAL_W = TOTAL_W_DEF,
    localparam int IW     = (N_ITEMS > 1) ? $clog2(N_ITEMS) : 1
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [1:0]         req_op,
    input  logic [IW-1:0]      req_item,
    input  logic [QTY_W-1:0]   req_data,
    output logic               rsp_valid,
    output logic               rsp_ok,
    output logic [1:0]         rsp_err,
    output logic [TOTAL_W-1:0] line_price,
    output logic [QTY_W-1:0]   stock_out,
    output logic [TOTAL_W-1:0] bill_total
);

    state_e              state_q;
    logic [1:0]          op_q;
    logic [IW-1:0]       item_q;
    logic [QTY_W-1:0]    data_q;
    logic [PRICE_W-1:0]  price_q [N_ITEMS];
    logic [QTY_W-1:0]    stock_q [N_ITEMS];
    logic [TOTAL_W-1:0]  bill_q;
    logic [TOTAL_W-1:0]  line_q;
    logic [QTY_W-1:0]    stock_out_q;
    logic                ok_q;
    logic [1:0]          err_q;
    logic                rsp_valid_q;
    logic                ready_q;

    logic [QTY_W-1:0]    cur_stock;
    logic [PRICE_W-1:0]  cur_price;
    logic [QTY_W:0]      restock_sum;
    logic [TOTAL_W:0]    bill_sum;
    logic [QTY_W-1:0]    stock_left;
    logic                sell_short;
    logic                mult_start;
    logic                mult_done;
    logic [TOTAL_W-1:0]  product;

    assign cur_stock   = stock_q[item_q];
    assign cur_price   = price_q[item_q];
    // Guard bits catch overflow before anything is committed.
    assign restock_sum = {1'b0, cur_stock} + {1'b0, data_q};
    assign bill_sum    = {1'b0, bill_q} + {1'b0, product};
    assign sell_short  = data_q > cur_stock;
    assign stock_left  = cur_stock - data_q;
    assign mult_start  = (state_q == S_CHECK) && (op_q == OP_SELL) && !sell_short;

    fcims_seq_mult #(
        .A_W (PRICE_W),
        .B_W (QTY_W),
        .P_W (TOTAL_W)
    ) u_mult (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (mult_start),
        .a       (cur_price),
        .b       (data_q),
        .done    (mult_done),
        .product (product)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            op_q        <= '0;
            item_q      <= '0;
            data_q      <= '0;
            bill_q      <= '0;
            line_q      <= '0;
            stock_out_q <= '0;
            ok_q        <= 1'b0;
            err_q       <= ERR_NONE;
            rsp_valid_q <= 1'b0;
            ready_q     <= 1'b0;
            for (int i = 0; i < N_ITEMS; i++) begin
                price_q[i] <= '0;
                stock_q[i] <= '0;
            end
        end else begin
            rsp_valid_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    ready_q <= 1'b1;
                    if (req_valid && ready_q) begin
                        op_q    <= req_op;
                        item_q  <= req_item;
                        data_q  <= req_data;
                        ready_q <= 1'b0;
                        state_q <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (op_q == OP_SELL && sell_short) begin
                        ok_q        <= 1'b0;
                        err_q       <= ERR_STOCK;
                        line_q      <= '0;
                        stock_out_q <= cur_stock;
                        rsp_valid_q <= 1'b1;
                        state_q     <= S_RESP;
                    end else if (op_q == OP_RESTOCK && restock_sum[QTY_W]) begin
                        ok_q        <= 1'b0;
                        err_q       <= ERR_OVF;
                        line_q      <= '0;
                        stock_out_q <= cur_stock;
                        rsp_valid_q <= 1'b1;
                        state_q     <= S_RESP;
                    end else if (op_q == OP_SELL) begin
                        state_q <= S_MULT;
                    end else begin
                        state_q <= S_COMMIT;
                    end
                end
                S_MULT: begin
                    if (mult_done) begin
                        state_q <= S_COMMIT;
                    end
                end
                S_COMMIT: begin
                    rsp_valid_q <= 1'b1;
                    state_q     <= S_RESP;
                    unique case (op_q)
                        OP_SELL: begin
                            line_q <= product;
                            if (bill_sum[TOTAL_W]) begin
                                ok_q        <= 1'b0;
                                err_q       <= ERR_BILL;
                                stock_out_q <= cur_stock;
                            end else begin
                                ok_q            <= 1'b1;
                                err_q           <= ERR_NONE;
                                stock_q[item_q] <= stock_left;
                                stock_out_q     <= stock_left;
                                bill_q          <= bill_sum[TOTAL_W-1:0];
                            end
                        end
                        OP_RESTOCK: begin
                            ok_q            <= 1'b1;
                            err_q           <= ERR_NONE;
                            line_q          <= '0;
                            stock_q[item_q] <= restock_sum[QTY_W-1:0];
                            stock_out_q     <= restock_sum[QTY_W-1:0];
                        end
                        OP_SET_PRICE: begin
                            ok_q            <= 1'b1;
                            err_q           <= ERR_NONE;
                            line_q          <= '0;
                            price_q[item_q] <= PRICE_W'(data_q);
                            stock_out_q     <= cur_stock;
                        end
                        OP_CLOSE_BILL: begin
                            ok_q        <= 1'b1;
                            err_q       <= ERR_NONE;
                            line_q      <= bill_q;
                            bill_q      <= '0;
                            stock_out_q <= cur_stock;
                        end
                    endcase
                end
                S_RESP: begin
                    ready_q <= 1'b1;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign req_ready  = ready_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_ok     = ok_q;
    assign rsp_err    = err_q;
    assign line_price = line_q;
    assign stock_out  = stock_out_q;
    assign bill_total = bill_q;

endmodule
